// File: rtl/descriptor_dispatch_arbiter.sv
// Two-way round-robin arbiter feeding the shared receive descriptor channel.
// Holds each granted descriptor until downstream acks or the ack timer expires.
module descriptor_dispatch_arbiter #(
  parameter int CNT_WIDTH   = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [47:0]          iv_nip_tsntag,
  input  logic [8:0]           iv_nip_bufid,
  input  logic                 i_nip_descriptor_wr,
  output logic                 o_nip_descriptor_ack,
  input  logic [47:0]          iv_ip_tsntag,
  input  logic [8:0]           iv_ip_bufid,
  input  logic                 i_ip_descriptor_wr,
  output logic                 o_ip_descriptor_ack,
  output logic [47:0]          ov_tsntag,
  output logic [8:0]           ov_bufid,
  output logic                 o_descriptor_wr,
  input  logic                 i_descriptor_ack,
  output logic                 o_descriptor_drop_pulse,
  output logic [CNT_WIDTH-1:0] ov_nip_grant_cnt,
  output logic [CNT_WIDTH-1:0] ov_ip_grant_cnt,
  output logic [CNT_WIDTH-1:0] ov_drop_cnt,
  output logic [1:0]           arb_state
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST =
    (ACK_TIMEOUT > 0) ? TW'(ACK_TIMEOUT - 1) : '0;

  state_t        state, state_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          last_ip;
  logic          grant_nip, grant_ip;
  logic          done, drop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    to_nxt    = to_cnt;
    grant_nip = 1'b0;
    grant_ip  = 1'b0;
    done      = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        // last_ip set means non-IP owns the tie
        if (i_nip_descriptor_wr &&
            (!i_ip_descriptor_wr || last_ip))
          grant_nip = 1'b1;
        else if (i_ip_descriptor_wr)
          grant_ip = 1'b1;
        if (grant_nip || grant_ip) begin
          state_nxt = WAIT_ACK;
          to_nxt    = '0;
        end
      end
      WAIT_ACK: begin
        if (i_descriptor_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (ACK_TIMEOUT != 0) begin
          if (to_cnt == TO_LAST) begin
            drop      = 1'b1;
            state_nxt = IDLE;
          end else begin
            to_nxt = to_cnt + TW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt                  <= '0;
      last_ip                 <= 1'b1;
      ov_tsntag               <= '0;
      ov_bufid                <= '0;
      o_descriptor_wr         <= 1'b0;
      o_nip_descriptor_ack    <= 1'b0;
      o_ip_descriptor_ack     <= 1'b0;
      o_descriptor_drop_pulse <= 1'b0;
      ov_nip_grant_cnt        <= '0;
      ov_ip_grant_cnt         <= '0;
      ov_drop_cnt             <= '0;
    end else begin
      to_cnt                  <= to_nxt;
      o_nip_descriptor_ack    <= grant_nip;
      o_ip_descriptor_ack     <= grant_ip;
      o_descriptor_drop_pulse <= drop;
      if (grant_nip) begin
        ov_tsntag        <= iv_nip_tsntag;
        ov_bufid         <= iv_nip_bufid;
        ov_nip_grant_cnt <= ov_nip_grant_cnt + CNT_WIDTH'(1);
        last_ip          <= 1'b0;
      end
      if (grant_ip) begin
        ov_tsntag       <= iv_ip_tsntag;
        ov_bufid        <= iv_ip_bufid;
        ov_ip_grant_cnt <= ov_ip_grant_cnt + CNT_WIDTH'(1);
        last_ip         <= 1'b1;
      end
      if (grant_nip || grant_ip)
        o_descriptor_wr <= 1'b1;
      else if (done || drop)
        o_descriptor_wr <= 1'b0;
      if (drop)
        ov_drop_cnt <= ov_drop_cnt + CNT_WIDTH'(1);
    end
  end

  assign arb_state = {1'b0, state};

endmodule

// File: tb/tb_descriptor_dispatch_arbiter.sv
// Directed bench for descriptor_dispatch_arbiter.
// A second, 2-bit-counter instance shares the stimulus to exercise wrap.
module tb_descriptor_dispatch_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] nip_tag = '0;
  logic [8:0]  nip_buf = '0;
  logic        nip_wr  = 1'b0;
  logic [47:0] ip_tag  = '0;
  logic [8:0]  ip_buf  = '0;
  logic        ip_wr   = 1'b0;
  logic        ds_ack  = 1'b0;

  logic        nip_ack, ip_ack, wr, drop;
  logic [47:0] tag;
  logic [8:0]  buf_id;
  logic [15:0] nip_cnt, ip_cnt, drop_cnt;
  logic [1:0]  st;

  logic        w_nip_ack, w_ip_ack, w_wr, w_drop;
  logic [47:0] w_tag;
  logic [8:0]  w_buf;
  logic [1:0]  w_nip_cnt, w_ip_cnt, w_drop_cnt;
  logic [1:0]  w_st;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  descriptor_dispatch_arbiter #(
    .CNT_WIDTH(16), .ACK_TIMEOUT(4)
  ) u_dut (
    .i_clk(clk), .i_rst(rst),
    .iv_nip_tsntag(nip_tag), .iv_nip_bufid(nip_buf),
    .i_nip_descriptor_wr(nip_wr), .o_nip_descriptor_ack(nip_ack),
    .iv_ip_tsntag(ip_tag), .iv_ip_bufid(ip_buf),
    .i_ip_descriptor_wr(ip_wr), .o_ip_descriptor_ack(ip_ack),
    .ov_tsntag(tag), .ov_bufid(buf_id),
    .o_descriptor_wr(wr), .i_descriptor_ack(ds_ack),
    .o_descriptor_drop_pulse(drop),
    .ov_nip_grant_cnt(nip_cnt), .ov_ip_grant_cnt(ip_cnt),
    .ov_drop_cnt(drop_cnt), .arb_state(st)
  );

  descriptor_dispatch_arbiter #(
    .CNT_WIDTH(2), .ACK_TIMEOUT(4)
  ) u_w2 (
    .i_clk(clk), .i_rst(rst),
    .iv_nip_tsntag(nip_tag), .iv_nip_bufid(nip_buf),
    .i_nip_descriptor_wr(nip_wr), .o_nip_descriptor_ack(w_nip_ack),
    .iv_ip_tsntag(ip_tag), .iv_ip_bufid(ip_buf),
    .i_ip_descriptor_wr(ip_wr), .o_ip_descriptor_ack(w_ip_ack),
    .ov_tsntag(w_tag), .ov_bufid(w_buf),
    .o_descriptor_wr(w_wr), .i_descriptor_ack(ds_ack),
    .o_descriptor_drop_pulse(w_drop),
    .ov_nip_grant_cnt(w_nip_cnt), .ov_ip_grant_cnt(w_ip_cnt),
    .ov_drop_cnt(w_drop_cnt), .arb_state(w_st)
  );

  task automatic check(input string name,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    check("rst_wr", 64'(wr), 64'd0);
    check("rst_tag", 64'(tag), 64'd0);
    check("rst_buf", 64'(buf_id), 64'd0);
    check("rst_acks", 64'({nip_ack, ip_ack, drop}), 64'd0);
    check("rst_cnts", 64'({nip_cnt, ip_cnt, drop_cnt}), 64'd0);
    check("rst_state", 64'(st), 64'd0);
    rst = 1'b0;

    // ack in IDLE is ignored
    ds_ack = 1'b1;
    tick();
    check("idle_ack_wr", 64'(wr), 64'd0);
    check("idle_ack_st", 64'(st), 64'd0);
    ds_ack = 1'b0;

    // single non-IP grant, ack in 4th WAIT_ACK cycle
    nip_tag = 48'h0000_1111_2222;
    nip_buf = 9'h05;
    nip_wr  = 1'b1;
    tick();
    check("t1_nip_ack", 64'(nip_ack), 64'd1);
    check("t1_ip_ack", 64'(ip_ack), 64'd0);
    check("t1_wr", 64'(wr), 64'd1);
    check("t1_buf", 64'(buf_id), 64'h05);
    check("t1_tag", 64'(tag), 64'h0000_1111_2222);
    check("t1_st", 64'(st), 64'd1);
    check("t1_cnt", 64'(nip_cnt), 64'd1);
    nip_wr = 1'b0;
    tick();
    check("t1_ack_pulse", 64'(nip_ack), 64'd0);
    check("t1_wr_hold", 64'(wr), 64'd1);
    tick();
    tick();
    check("t1_wr_c4", 64'(wr), 64'd1);
    ds_ack = 1'b1;
    tick();
    ds_ack = 1'b0;
    check("t1_wr_done", 64'(wr), 64'd0);
    check("t1_st_done", 64'(st), 64'd0);
    check("t1_no_drop", 64'(drop), 64'd0);
    check("t1_drop_cnt", 64'(drop_cnt), 64'd0);
    check("t1_buf_kept", 64'(buf_id), 64'h05);

    // continuous contention, round robin from reset
    do_reset();
    nip_tag = 48'hAAAA_0000_000A;
    nip_buf = 9'h0A;
    ip_tag  = 48'hBBBB_0000_001B;
    ip_buf  = 9'h1B;
    nip_wr  = 1'b1;
    ip_wr   = 1'b1;
    for (int g = 0; g < 8; g++) begin
      tick();
      check("rr_nip_ack", 64'(nip_ack), 64'(g % 2 == 0));
      check("rr_ip_ack", 64'(ip_ack), 64'(g % 2 == 1));
      check("rr_wr", 64'(wr), 64'd1);
      check("rr_buf", 64'(buf_id),
            (g % 2 == 0) ? 64'h0A : 64'h1B);
      ds_ack = 1'b1;
      tick();
      ds_ack = 1'b0;
      check("rr_gap", 64'(wr), 64'd0);
    end
    nip_wr = 1'b0;
    ip_wr  = 1'b0;
    check("rr_nip_cnt", 64'(nip_cnt), 64'd4);
    check("rr_ip_cnt", 64'(ip_cnt), 64'd4);
    check("rr_w2_nip_cnt", 64'(w_nip_cnt), 64'd0);

    // timeout drop with no downstream ack
    ip_tag = 48'h0123_4567_89AB;
    ip_buf = 9'h1C3;
    ip_wr  = 1'b1;
    tick();
    check("to_ip_ack", 64'(ip_ack), 64'd1);
    check("to_buf", 64'(buf_id), 64'h1C3);
    ip_wr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("to_wr_hold", 64'(wr), 64'd1);
      check("to_no_drop", 64'(drop), 64'd0);
    end
    tick();
    check("to_wr_clr", 64'(wr), 64'd0);
    check("to_drop", 64'(drop), 64'd1);
    check("to_drop_cnt", 64'(drop_cnt), 64'd1);
    check("to_st", 64'(st), 64'd0);
    // pointer stayed on IP, so non-IP wins the next tie
    nip_wr = 1'b1;
    ip_wr  = 1'b1;
    tick();
    check("to_drop_pulse", 64'(drop), 64'd0);
    check("to_next_nip", 64'(nip_ack), 64'd1);
    check("to_next_ip", 64'(ip_ack), 64'd0);
    nip_wr = 1'b0;
    ip_wr  = 1'b0;
    ds_ack = 1'b1;
    tick();
    ds_ack = 1'b0;
    check("to_drop_cnt2", 64'(drop_cnt), 64'd1);

    // five non-IP grants wrap the 2-bit counter
    do_reset();
    for (int g = 0; g < 5; g++) begin
      nip_wr = 1'b1;
      tick();
      check("wrap_ack", 64'(nip_ack), 64'd1);
      nip_wr = 1'b0;
      ds_ack = 1'b1;
      tick();
      ds_ack = 1'b0;
    end
    check("wrap_w2_cnt", 64'(w_nip_cnt), 64'd1);
    check("wrap_cnt", 64'(nip_cnt), 64'd5);

    // asynchronous reset during WAIT_ACK
    nip_wr = 1'b1;
    tick();
    nip_wr = 1'b0;
    ip_wr  = 1'b1;
    tick();
    check("ar_wr_before", 64'(wr), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_wr", 64'(wr), 64'd0);
    check("ar_tag", 64'(tag), 64'd0);
    check("ar_st", 64'(st), 64'd0);
    check("ar_cnt", 64'(nip_cnt), 64'd0);
    check("ar_drop", 64'(drop), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("ar_ip_ack", 64'(ip_ack), 64'd1);
    check("ar_ip_cnt", 64'(ip_cnt), 64'd1);
    check("ar_buf", 64'(buf_id), 64'h1C3);
    ip_wr  = 1'b0;
    ds_ack = 1'b1;
    tick();
    ds_ack = 1'b0;
    nip_wr = 1'b1;
    ip_wr  = 1'b1;
    tick();
    check("ar_next_nip", 64'(nip_ack), 64'd1);
    check("ar_next_ip", 64'(ip_ack), 64'd0);
    nip_wr = 1'b0;
    ip_wr  = 1'b0;
    ds_ack = 1'b1;
    tick();
    ds_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
